// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: 33-cycle shift-add multiply and restoring divide, plus MTHI/MTLO.
// Latency 33 cycles from acceptance to the done pulse; starts are ignored while busy.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  op,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] opb;
  logic        is_div;
  logic        neg_lo;
  logic        neg_hi;

  logic        signed_op;
  logic        div_op;
  logic        b_zero;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic [32:0] div_diff;
  logic [63:0] mul_res;
  logic [31:0] quo;
  logic [31:0] rem;

  // A zero divisor keeps a unsigned so hi ends up holding the raw dividend.
  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    div_op    = (op == OP_DIV) || (op == OP_DIVU);
    b_zero    = (b == 32'd0);
    mag_a     = (signed_op && a[31] && !(div_op && b_zero)) ? -a : a;
    mag_b     = (signed_op && b[31]) ? -b : b;
    mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opb : 32'd0)};
    div_sh    = acc[63:31];
    div_diff  = div_sh - {1'b0, opb};
    mul_res   = neg_lo ? -acc : acc;
    quo       = neg_lo ? -acc[31:0] : acc[31:0];
    rem       = neg_hi ? -acc[63:32] : acc[63:32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      acc    <= 64'd0;
      opb    <= 32'd0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                acc    <= {32'd0, mag_b};
                opb    <= mag_a;
                is_div <= 1'b0;
                neg_lo <= signed_op && (a[31] ^ b[31]);
                neg_hi <= 1'b0;
                cnt    <= 5'd0;
                busy   <= 1'b1;
                state  <= MUL;
              end
              OP_DIV, OP_DIVU: begin
                acc    <= {32'd0, mag_a};
                opb    <= mag_b;
                is_div <= 1'b1;
                neg_lo <= signed_op && (a[31] ^ b[31]) && !b_zero;
                neg_hi <= signed_op && a[31] && !b_zero;
                cnt    <= 5'd0;
                busy   <= 1'b1;
                state  <= DIV;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[31:1]};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        DIV: begin
          // Restoring step: keep the trial difference only when it did not borrow.
          if (!div_diff[32]) acc <= {div_diff[31:0], acc[30:0], 1'b1};
          else               acc <= {div_sh[31:0], acc[30:0], 1'b0};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            hi <= rem;
            lo <= quo;
          end else begin
            hi <= mul_res[63:32];
            lo <= mul_res[31:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          cnt   <= 5'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
